// File: rtl/ds_pkg.sv
// ds_pkg: shared mode codes, FSM state type and accumulator sizing for downsamp_multi.
package ds_pkg;
    localparam logic [1:0] DS_MAX  = 2'd0;
    localparam logic [1:0] DS_MIN  = 2'd1;
    localparam logic [1:0] DS_MEAN = 2'd2;
    localparam logic [1:0] DS_PICK = 2'd3;

    typedef enum logic {IDLE, ACCUM} ds_state_t;

    // MEAN sums up to 2^max_decim_log2 samples, so this many guard bits prevent wrap.
    function automatic int acc_w(input int data_width, input int max_decim_log2);
        return data_width + max_decim_log2;
    endfunction
endpackage

// File: rtl/downsamp_multi_if.sv
// downsamp_multi_if: reduced-frame output stream with valid/ready handshake.
interface downsamp_multi_if #(
    parameter int DATA_WIDTH = 12,
    parameter int CHANNELS   = 2
);
    logic [CHANNELS*DATA_WIDTH-1:0] dout;
    logic                           out_valid;
    logic                           out_ready;
    modport master (output dout, output out_valid, input out_ready);
    modport slave  (input dout, input out_valid, output out_ready);
endinterface

// File: rtl/ds_lane.sv
// ds_lane: one lane's frame accumulator; result reflects the accumulator after this cycle's sample.
module ds_lane
    import ds_pkg::*;
#(
    parameter int DATA_WIDTH     = 12,
    parameter int MAX_DECIM_LOG2 = 8,
    parameter int SW             = $clog2(MAX_DECIM_LOG2 + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         update,
    input  logic [1:0]                   mode,
    input  logic [SW-1:0]                shift,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0]        result
);
    localparam int AW = acc_w(DATA_WIDTH, MAX_DECIM_LOG2);

    logic signed [AW-1:0] acc, nxt, x, upd, sh;

    assign x = AW'(din);

    always_comb begin
        upd = mode == DS_MAX  ? (x > acc ? x : acc) :
              mode == DS_MIN  ? (x < acc ? x : acc) :
              mode == DS_MEAN ? acc + x : acc;
        nxt = load ? x : update ? upd : acc;
        sh  = nxt >>> shift;
    end

    // Completion registers the result from nxt so dout lands one clock after the last sample.
    assign result = mode == DS_MEAN ? sh[DATA_WIDTH-1:0] : nxt[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) acc <= '0;
        else     acc <= nxt;
    end
endmodule

// File: rtl/downsamp_multi.sv
// downsamp_multi: multi-lane 2^ratio_log2 decimator (MAX/MIN/MEAN/PICK) with one-entry
// valid/ready output register and a sticky overflow flag for dropped frames.
module downsamp_multi
    import ds_pkg::*;
#(
    parameter int DATA_WIDTH     = 12,
    parameter int CHANNELS       = 2,
    parameter int MAX_DECIM_LOG2 = 8,
    parameter int RW             = $clog2(MAX_DECIM_LOG2 + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic [CHANNELS*DATA_WIDTH-1:0] din,
    input  logic [1:0]                     mode,
    input  logic [RW-1:0]                  ratio_log2,
    input  logic                           clr_ovf,
    output logic                           overflow,
    downsamp_multi_if.master               res
);
    localparam int CW = MAX_DECIM_LOG2;

    ds_state_t                      state;
    logic [1:0]                     mode_q, mode_cur;
    logic [RW-1:0]                  r_q, r_clamp, shift_cur;
    logic [CW-1:0]                  cnt, last_q;
    logic                           idle, load, update, done;
    logic [CHANNELS*DATA_WIDTH-1:0] nxt_res;

    always_comb begin
        idle      = state == IDLE;
        r_clamp   = ratio_log2 > RW'(MAX_DECIM_LOG2) ? RW'(MAX_DECIM_LOG2) : ratio_log2;
        mode_cur  = idle ? mode : mode_q;
        shift_cur = idle ? r_clamp : r_q;
        load      = idle && ena;
        update    = !idle && ena;
        done      = ena && (idle ? r_clamp == '0 : cnt == last_q);
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        ds_lane #(
            .DATA_WIDTH     (DATA_WIDTH),
            .MAX_DECIM_LOG2 (MAX_DECIM_LOG2),
            .SW             (RW)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .load   (load),
            .update (update),
            .mode   (mode_cur),
            .shift  (shift_cur),
            .din    (din[k*DATA_WIDTH +: DATA_WIDTH]),
            .result (nxt_res[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mode_q        <= DS_MAX;
            r_q           <= '0;
            cnt           <= '0;
            last_q        <= '0;
            res.dout      <= '0;
            res.out_valid <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (load) begin
                mode_q <= mode;
                r_q    <= r_clamp;
                last_q <= CW'((32'd1 << r_clamp) - 32'd1);
                cnt    <= done ? '0 : CW'(1);
                state  <= done ? IDLE : ACCUM;
            end else if (update) begin
                cnt   <= done ? '0 : cnt + CW'(1);
                state <= done ? IDLE : ACCUM;
            end
            // A pop in the completing cycle frees the register, so the new result is not dropped.
            if (done && (!res.out_valid || res.out_ready)) begin
                res.dout      <= nxt_res;
                res.out_valid <= 1'b1;
            end else if (res.out_valid && res.out_ready) begin
                res.out_valid <= 1'b0;
            end
            overflow <= clr_ovf ? 1'b0 : (done && res.out_valid && !res.out_ready) ? 1'b1 : overflow;
        end
    end
endmodule

// File: tb/tb_downsamp_multi.sv
// tb_downsamp_multi: directed vectors with a queue scoreboard checked by a handshake monitor.
module tb_downsamp_multi;
    logic        clk = 0;
    logic        rst = 1;
    logic        ena = 0;
    logic [23:0] din = '0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  ratio_log2 = 4'd0;
    logic        clr_ovf = 0;
    logic        overflow;
    int          n_vec = 0;
    int          n_miss = 0;
    logic [23:0] q[$];

    downsamp_multi_if #(.DATA_WIDTH(12), .CHANNELS(2)) res ();

    downsamp_multi #(.DATA_WIDTH(12), .CHANNELS(2), .MAX_DECIM_LOG2(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .din        (din),
        .mode       (mode),
        .ratio_log2 (ratio_log2),
        .clr_ovf    (clr_ovf),
        .overflow   (overflow),
        .res        (res.master)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pk(input int a, input int b);
        return {12'(b), 12'(a)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic put(input int a, input int b);
        ena = 1;
        din = pk(a, b);
        tick(1);
        ena = 0;
    endtask

    // Inputs change only at posedge+2, so at negedge the handshake about to occur is stable.
    always @(negedge clk) begin
        if (!rst && res.out_valid && res.out_ready) begin
            n_vec++;
            if (q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_out: got %h with empty scoreboard", res.dout);
            end else begin
                logic [23:0] e;
                e = q.pop_front();
                if (res.dout !== e) begin
                    n_miss++;
                    $display("FAIL dout: got %h expected %h", res.dout, e);
                end
            end
        end
    end

    initial begin
        res.out_ready = 1;
        tick(3);
        chk("rst_dout", 32'(res.dout), 32'h0);
        chk("rst_valid", 32'(res.out_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 0;
        tick(1);

        mode = 2'd0; ratio_log2 = 4'd2;
        q.push_back(pk(7, 2047));
        put(3, -2048); put(-5, 0); put(7, -1);
        chk("t1_pre_valid", 32'(res.out_valid), 32'd0);
        put(1, 2047);
        chk("t1_valid", 32'(res.out_valid), 32'd1);
        tick(2);

        mode = 2'd2; ratio_log2 = 4'd3;
        q.push_back(pk(-3, 1));
        for (int i = 0; i < 8; i++) put(-3, i == 7 ? 2 : 1);
        q.push_back(pk(-1, 2047));
        for (int i = 0; i < 8; i++) put(i == 0 ? -1 : 0, 2047);
        tick(2);

        ratio_log2 = 4'd15;
        q.push_back(pk(-2048, 2047));
        for (int i = 0; i < 256; i++) put(-2048, 2047);
        tick(2);

        ratio_log2 = 4'd0; mode = 2'd3;
        for (int i = 0; i < 3; i++) begin
            q.push_back(pk(10 + i, -10 - i));
            put(10 + i, -10 - i);
            chk("t3_valid_pick", 32'(res.out_valid), 32'd1);
        end
        mode = 2'd1;
        q.push_back(pk(-7, 5)); put(-7, 5);
        chk("t3_valid_min", 32'(res.out_valid), 32'd1);
        q.push_back(pk(100, -100)); put(100, -100);
        tick(2);

        res.out_ready = 0; mode = 2'd0; ratio_log2 = 4'd1;
        q.push_back(pk(3, 4));
        put(1, 2); put(3, 4);
        put(5, 6); put(7, 8);
        chk("t4_hold", 32'(res.dout), 32'(pk(3, 4)));
        chk("t4_ovf_set", 32'(overflow), 32'd1);
        clr_ovf = 1; tick(1); clr_ovf = 0;
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        put(9, 10);
        res.out_ready = 1;
        q.push_back(pk(11, 12));
        put(11, 12);
        chk("t4_no_bubble", 32'(res.out_valid), 32'd1);
        chk("t4_no_ovf", 32'(overflow), 32'd0);
        tick(2);

        mode = 2'd0; ratio_log2 = 4'd2;
        q.push_back(pk(9, -1));
        put(1, -1);
        mode = 2'd1; ratio_log2 = 4'd1;
        put(9, -9); put(2, -2); put(4, -4);
        q.push_back(pk(-6, 3));
        put(5, 5); put(-6, 3);
        tick(2);

        mode = 2'd0; ratio_log2 = 4'd2;
        put(1, 1); put(2, 2);
        rst = 1; tick(2); rst = 0;
        tick(2);
        chk("t6_rst_valid", 32'(res.out_valid), 32'd0);
        chk("t6_rst_dout", 32'(res.dout), 32'h0);
        q.push_back(pk(8, 3));
        put(4, -4); tick(2); put(8, -8); tick(1); put(-3, 3);
        chk("t6_gap_pending", 32'(res.out_valid), 32'd0);
        put(6, -6);
        chk("t6_gap_valid", 32'(res.out_valid), 32'd1);
        tick(3);

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
